// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, optional overlap,
// and a saturating match counter. The FSM state is the history fill count
// (S0..S(PAT_LEN)). The match is flagged on the edge where the last pattern
// bit is sampled, and y is the registered copy of that flag.
module seq_detector_param #(
    parameter int unsigned        PAT_LEN = 5,        // 2..16
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b11100, // MSB is the first bit received
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8         // 1..32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             x,
    input  logic                             ld,
    input  logic [PAT_LEN-1:0]               pat_in,
    input  logic                             clr_cnt,
    output logic                             y,
    output logic [CNT_W-1:0]                 match_cnt,
    output logic                             cnt_sat,
    output logic [$clog2(PAT_LEN+1)-1:0]     fill
);

    localparam int unsigned       FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill_inc;
    logic               match;

    // Candidate history/fill for a sampled bit, and the match decision.
    always_comb begin
        hist_next = {hist_q[PAT_LEN-2:0], x};
        fill_inc  = (fill_q < FILL_FULL) ? fill_q + FILL_W'(1) : fill_q;
        match     = en && !ld && (fill_inc == FILL_FULL) && (hist_next == pat_q);
    end

    // Next state of pattern, history and fill (the FSM state); ld beats en.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = match;
        if (ld) begin
            // The x sample on a load edge is discarded.
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
            y_d    = 1'b0;
        end else if (en) begin
            if (match && !OVERLAP) begin
                // Non-overlapping: the next match needs PAT_LEN fresh bits.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_next;
                fill_d = fill_inc;
            end
        end
    end

    // Saturating match counter; clear wins over a simultaneous match.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = (cnt_q == CNT_MAX);
    assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Four instances share the stimulus:
//   d0 defaults, d1 PAT_LEN=4 overlap, d2 PAT_LEN=4 no overlap, d3 CNT_W=2.
// Each vector carries per-instance expectations plus a mask of which
// instances are checked; vectors go through a scoreboard queue.
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, x, ld, clr_cnt;
    logic [4:0] pat5;
    logic [3:0] pat4;

    logic       y0, y1, y2, y3;
    logic [7:0] cnt0;
    logic [7:0] cnt1, cnt2;
    logic [1:0] cnt3;
    logic       sat0, sat1, sat2, sat3;
    logic [2:0] fill0, fill1, fill2, fill3;

    seq_detector_param u_d0 (
        .clk(clk), .reset(reset), .en(en), .x(x), .ld(ld), .pat_in(pat5),
        .clr_cnt(clr_cnt), .y(y0), .match_cnt(cnt0), .cnt_sat(sat0), .fill(fill0)
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b0110), .OVERLAP(1'b1)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .x(x), .ld(ld), .pat_in(pat4),
        .clr_cnt(clr_cnt), .y(y1), .match_cnt(cnt1), .cnt_sat(sat1), .fill(fill1)
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b0110), .OVERLAP(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .en(en), .x(x), .ld(ld), .pat_in(pat4),
        .clr_cnt(clr_cnt), .y(y2), .match_cnt(cnt2), .cnt_sat(sat2), .fill(fill2)
    );

    seq_detector_param #(.CNT_W(2)) u_d3 (
        .clk(clk), .reset(reset), .en(en), .x(x), .ld(ld), .pat_in(pat5),
        .clr_cnt(clr_cnt), .y(y3), .match_cnt(cnt3), .cnt_sat(sat3), .fill(fill3)
    );

    typedef struct packed {
        logic       y;
        logic [7:0] cnt;
        logic [2:0] fill;
        logic       sat;
    } exp_t;

    typedef struct {
        logic             rst, en, x, ld, clr;
        logic [3:0]       chk;
        exp_t [3:0]       e;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];
    vec_t tbl[$];

    function automatic exp_t ex(input logic yv, input int c, input int f, input logic s);
        exp_t r;
        r.y    = yv;
        r.cnt  = 8'(c);
        r.fill = 3'(f);
        r.sat  = s;
        return r;
    endfunction

    function automatic vec_t mkv(input logic r, input logic e, input logic b,
                                 input logic l, input logic c, input logic [3:0] m);
        vec_t v;
        v.rst = r; v.en = e; v.x = b; v.ld = l; v.clr = c; v.chk = m;
        v.e   = '0;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        logic       ay, as;
        logic [7:0] ac;
        logic [2:0] af;
        for (int i = 0; i < 4; i++) begin
            if (v.chk[i]) begin
                case (i)
                    0:       begin ay = y0; ac = cnt0;         af = fill0; as = sat0; end
                    1:       begin ay = y1; ac = cnt1;         af = fill1; as = sat1; end
                    2:       begin ay = y2; ac = cnt2;         af = fill2; as = sat2; end
                    default: begin ay = y3; ac = {6'b0, cnt3}; af = fill3; as = sat3; end
                endcase
                cmp($sformatf("%s d%0d y", tag, i),    int'(ay), int'(v.e[i].y));
                cmp($sformatf("%s d%0d cnt", tag, i),  int'(ac), int'(v.e[i].cnt));
                cmp($sformatf("%s d%0d fill", tag, i), int'(af), int'(v.e[i].fill));
                cmp($sformatf("%s d%0d sat", tag, i),  int'(as), int'(v.e[i].sat));
            end
        end
    endtask

    // Drive on the falling edge, push expectation, compare 1 ns after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t got;
        @(negedge clk);
        reset = v.rst; en = v.en; x = v.x; ld = v.ld; clr_cnt = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
        end else begin
            got = sb.pop_front();
            check_vec(got, tag);
        end
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", tag, i));
        tbl.delete();
    endtask

    task automatic do_reset(input string tag);
        vec_t v;
        v = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
        for (int i = 0; i < 4; i++) v.e[i] = ex(1'b0, 0, 0, 1'b0);
        apply(v, tag);
    endtask

    initial begin
        vec_t v;
        int   m;
        reset = 1'b0; en = 1'b0; x = 1'b0; ld = 1'b0; clr_cnt = 1'b0;
        pat5 = 5'b11100; pat4 = 4'b1010;

        // Reset state of all instances.
        do_reset("rst0");

        // Repeated 11100: pulses every 5 bits; d3 saturates at 3.
        for (int k = 1; k <= 25; k++) begin
            v = mkv(1'b1, 1'b1, ((k - 1) % 5) < 3, 1'b0, 1'b0, 4'b1001);
            m = k / 5;
            v.e[0] = ex(k % 5 == 0, m, (k < 5) ? k : 5, 1'b0);
            v.e[3] = ex(k % 5 == 0, (m < 3) ? m : 3, (k < 5) ? k : 5, m >= 3);
            tbl.push_back(v);
        end
        run_tbl("stream");

        // Pattern load 1010 then 1010101 into both 4-bit instances.
        do_reset("rst1");
        v = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
        v.e[1] = ex(1'b0, 0, 0, 1'b0);
        v.e[2] = ex(1'b0, 0, 0, 1'b0);
        tbl.push_back(v);
        for (int k = 1; k <= 7; k++) begin
            v = mkv(1'b1, 1'b1, (k % 2) == 1, 1'b0, 1'b0, 4'b0110);
            v.e[1] = ex(k == 4 || k == 6, (k >= 6) ? 2 : (k >= 4) ? 1 : 0,
                        (k < 4) ? k : 4, 1'b0);
            v.e[2] = ex(k == 4, (k >= 4) ? 1 : 0, (k < 4) ? k : k - 4, 1'b0);
            tbl.push_back(v);
        end
        run_tbl("load");

        // en gaps between bits 3 and 4 of 11100.
        do_reset("rst2");
        for (int k = 0; k < 8; k++) begin
            logic gap;
            int   f;
            gap = (k >= 3 && k <= 5);
            f   = (k < 3) ? k + 1 : (k <= 5) ? 3 : k - 2;
            v = mkv(1'b1, !gap, k < 3, 1'b0, 1'b0, 4'b0001);
            v.e[0] = ex(k == 7, (k == 7) ? 1 : 0, f, 1'b0);
            tbl.push_back(v);
        end
        run_tbl("gap");

        // Reset mid-sequence discards 1110; a following 0 must not match.
        do_reset("rst3");
        for (int k = 1; k <= 4; k++) begin
            v = mkv(1'b1, 1'b1, k < 4, 1'b0, 1'b0, 4'b0001);
            v.e[0] = ex(1'b0, 0, k, 1'b0);
            tbl.push_back(v);
        end
        run_tbl("pre");
        @(negedge clk);
        reset = 1'b0;
        #1;
        cmp("async fill", int'(fill0), 0);
        cmp("async y", int'(y0), 0);
        for (int k = 0; k < 2; k++) begin
            v = mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
            v.e[0] = ex(1'b0, 0, 0, 1'b0);
            tbl.push_back(v);
        end
        v = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
        v.e[0] = ex(1'b0, 0, 1, 1'b0);
        tbl.push_back(v);
        run_tbl("midrst");

        // clr_cnt on the second match edge: y still pulses, count cleared.
        do_reset("rst4");
        for (int k = 1; k <= 15; k++) begin
            v = mkv(1'b1, 1'b1, ((k - 1) % 5) < 3, 1'b0, k == 10, 4'b0001);
            m = (k < 5) ? 0 : (k < 10) ? 1 : (k < 15) ? 0 : 1;
            v.e[0] = ex(k % 5 == 0, m, (k < 5) ? k : 5, 1'b0);
            tbl.push_back(v);
        end
        run_tbl("clr");

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have these parameters:
- PAT_LEN, default 5: pattern length in bits; legal range 2..16.
- PATTERN, default 5'b11100: reset-time pattern, PAT_LEN bits wide; the MSB is the first bit received.
- OVERLAP, default 1: 1 = overlapping matches allowed; 0 = the next match needs PAT_LEN fresh bits.
- CNT_W, default 8: match counter width; legal range 1..32.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  sample qualifier; x is consumed only on edges where en=1.
- x  in  1  serial input bit.
- ld  in  1  synchronous pattern load strobe.
- pat_in  in  PAT_LEN  pattern captured when ld=1.
- clr_cnt  in  1  synchronous match counter clear.
- y  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  high while match_cnt is all ones.
- fill  out  log2(PAT_LEN+1)  number of valid history bits, 0..PAT_LEN.

Function
REQ-003 The block SHALL hold these registers: pat_reg (PAT_LEN bits), hist (PAT_LEN bits), fill, y, and match_cnt.
REQ-004 On an edge with en=1 and ld=0, the block SHALL compute hist_next = {hist[PAT_LEN-2:0], x} and load it into hist.
REQ-005 On an edge with en=1 and ld=0, if fill<PAT_LEN the block SHALL increment fill; fill SHALL saturate at PAT_LEN.
REQ-006 A match SHALL occur on an edge where en=1, ld=0, the incremented fill equals PAT_LEN, and hist_next==pat_reg.
REQ-007 On a match, y SHALL be 1 for exactly the following cycle; latency from the final pattern bit sampled to y high is 1 clock.
REQ-008 On every edge without a match, the block SHALL drive y to 0, including all edges where en=0.
REQ-009 With OVERLAP=1, fill SHALL stay at PAT_LEN after a match, so overlapping occurrences each produce a pulse.
REQ-010 With OVERLAP=0, a match SHALL set fill to 0 and hist to 0, so the next match needs PAT_LEN further sampled bits.
REQ-011 When en=0 and ld=0, hist and fill SHALL hold their values and no match SHALL occur.
REQ-012 When ld=1, the block SHALL set pat_reg to pat_in, set hist and fill to 0, and force y to 0 next cycle.
REQ-013 ld SHALL take priority over en; the x sample on that edge SHALL be discarded.
REQ-014 On each match, match_cnt SHALL increment by 1 and hold at 2^CNT_W-1 with no wrap.
REQ-015 cnt_sat SHALL be combinationally equal to (match_cnt == all ones).
REQ-016 When clr_cnt=1, match_cnt SHALL become 0.
REQ-017 clr_cnt SHALL win over a simultaneous match; y still pulses for that match.
REQ-018 clr_cnt SHALL not affect hist, fill or pat_reg.
REQ-019 Equivalent state-machine view: states S0..S(PAT_LEN) equal fill; the transition on en=1 is min(fill+1, PAT_LEN), or 0 on a match when OVERLAP=0.

Reset
REQ-020 While reset=0 (asynchronous, active-low), the block SHALL hold y=0, match_cnt=0, fill=0, hist=0 and pat_reg=PATTERN; cnt_sat follows match_cnt.
REQ-021 Reset asserted mid-sequence SHALL discard partial history; no match SHALL complete from bits sampled before reset.
REQ-022 After reset deasserts, the first en=1 edge SHALL be treated as bit 1 of a new sequence.

Verification
REQ-023 Defaults, en=1, x=111001110011100 -> y pulses 1 cycle after bits 5, 10 and 15; match_cnt=3; fill=5 at end.
REQ-024 ld with pat_in=4'b1010, PAT_LEN=4, x=1010101 -> OVERLAP=1: pulses after bits 4 and 6, match_cnt=2; OVERLAP=0: pulse after bit 4 only, match_cnt=1.
REQ-025 Defaults, x=11100 with en=0 for 3 cycles between bits 3 and 4 -> single pulse after bit 5; no y during gaps.
REQ-026 CNT_W=2, 5 consecutive default matches -> match_cnt 1,2,3,3,3; cnt_sat=1 from the 3rd match on.
REQ-027 Defaults, x=1110, then reset low for 2 cycles, then x=0 -> no pulse; y=0, match_cnt=0, fill=1 after the final bit.
REQ-028 clr_cnt=1 on the edge of the 2nd default match -> y pulses; match_cnt=0 next cycle, then 1 after the 3rd match.
